// File: rtl/dkongjr_obj_dma.sv
// dkongjr_obj_dma: copies a sprite attribute table from CPU work RAM into the inactive OBJ RAM bank.
// Optional macro DMA_VBLANK_GATE_EN restricts bus ownership to vertical blank.
module dkongjr_obj_dma #(
   parameter int RD_WAIT = 1,
   parameter int MAX_LEN = 512
) (
   input  logic        CLK_12M,
   input  logic        RST_4L,
   input  logic        I_START,
   input  logic [15:0] I_SRC_BASE,
   input  logic [9:0]  I_LEN,
   input  logic        I_2PSL,
   input  logic        I_VBLK,
   input  logic        I_BUSAKn,
   input  logic [7:0]  I_SRC_DB,
   output logic        O_BUSRQn,
   output logic [15:0] O_SRC_AB,
   output logic        O_SRC_RDn,
   output logic [9:0]  O_OBJ_AB,
   output logic [7:0]  O_OBJ_DB,
   output logic        O_OBJ_RQn,
   output logic        O_OBJ_WRn,
   output logic        O_BUSY,
   output logic        O_DONE
);
   localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, RD = 3'd2, WR = 3'd3, GAP = 3'd4, HOLD = 3'd5, REL = 3'd6;
   localparam logic [1:0] WAIT_L = 2'(RD_WAIT);
   localparam logic [9:0] MAX_L = 10'(MAX_LEN);

   logic [2:0]  state;
   logic [15:0] src;
   logic [8:0]  offset;
   logic [9:0]  count;
   logic [9:0]  len_eff;
   logic [1:0]  wait_cnt;
   logic        bank;
   logic        done_z;
   logic        pend;
   logic        park;
   logic        gate;
   logic        active;

   // gate is the permission to own the bus; it is constantly open unless vblank gating is built in
`ifdef DMA_VBLANK_GATE_EN
   assign gate = I_VBLK;
`else
   logic unused_vblk;
   assign gate = 1'b1;
   assign unused_vblk = I_VBLK;
`endif

   assign len_eff = (I_LEN > MAX_L) ? MAX_L : I_LEN;

   // strobes decode straight from the state so an asynchronous reset releases them at once
   always_comb begin
      active    = state inside {REQ, RD, WR, GAP, HOLD};
      O_BUSRQn  = !(active && !park);
      O_BUSY    = active || pend;
      O_SRC_RDn = state != RD;
      O_OBJ_RQn = state != WR;
      O_OBJ_WRn = state != WR;
      O_DONE    = done_z || (state == REL);
      O_SRC_AB  = src;
      O_OBJ_AB  = {bank, offset};
   end

   // transfer sequencer: request bus, read byte, write byte, advance, release
   always_ff @(posedge CLK_12M or negedge RST_4L) begin
      if (!RST_4L) begin
         state    <= IDLE;
         src      <= '0;
         offset   <= '0;
         count    <= '0;
         wait_cnt <= '0;
         bank     <= 1'b0;
         done_z   <= 1'b0;
         pend     <= 1'b0;
         park     <= 1'b0;
         O_OBJ_DB <= '0;
      end else begin
         done_z <= 1'b0;
         case (state)
            IDLE: begin
               if (pend) begin
                  if (gate) begin
                     pend  <= 1'b0;
                     state <= REQ;
                  end
               end else if (I_START) begin
                  src    <= I_SRC_BASE;
                  offset <= '0;
                  count  <= len_eff;
                  bank   <= ~I_2PSL;
                  if (len_eff == 10'd0) done_z <= 1'b1;
                  else if (gate) state <= REQ;
                  else pend <= 1'b1;
               end
            end
            REQ: if (!I_BUSAKn) state <= RD;
            RD: begin
               if (wait_cnt == WAIT_L) begin
                  O_OBJ_DB <= I_SRC_DB;
                  wait_cnt <= '0;
                  state    <= WR;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            WR: state <= GAP;
            GAP: begin
               src    <= src + 16'd1;
               offset <= offset + 9'd1;
               count  <= count - 10'd1;
               if (count == 10'd1) state <= REL;
               else if (!gate) begin
                  park  <= 1'b1;
                  state <= HOLD;
               end else if (I_BUSAKn) state <= HOLD;
               else state <= RD;
            end
            HOLD: begin
               if (park) begin
                  if (gate) begin
                     park  <= 1'b0;
                     state <= REQ;
                  end
               end else if (!I_BUSAKn) state <= RD;
            end
            REL: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dkongjr_obj_dma.sv
// tb_dkongjr_obj_dma: directed bench with a transfer-level write model for dkongjr_obj_dma.
`timescale 1ns/1ps
module tb_dkongjr_obj_dma;
   localparam int BPB = 4;

   typedef struct {
      logic [9:0]  ab;
      logic [7:0]  db;
      logic [15:0] sa;
   } wr_t;

   logic        clk = 0, rst_n = 0, start = 0, psl = 0, vblk = 1, busakn = 1;
   logic [15:0] base = 0;
   logic [9:0]  len = 0;
   logic [7:0]  src_db;
   logic        busrqn, src_rdn, obj_rqn, obj_wrn, busy, done;
   logic [15:0] src_ab;
   logic [9:0]  obj_ab;
   logic [7:0]  obj_db;

   int n_chk = 0, n_fail = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
   bit hold_bus = 0, chk_gap = 0, rq_low_seen = 0, prev_wrn = 1, prev_done = 0;
   logic [15:0] last_sa = 0;
   wr_t exp_q[$];
   logic [9:0] log_ab[$];
   logic [7:0] log_db[$];
   int log_cyc[$];

   dkongjr_obj_dma dut (
      .CLK_12M(clk), .RST_4L(rst_n), .I_START(start), .I_SRC_BASE(base), .I_LEN(len),
      .I_2PSL(psl), .I_VBLK(vblk), .I_BUSAKn(busakn), .I_SRC_DB(src_db),
      .O_BUSRQn(busrqn), .O_SRC_AB(src_ab), .O_SRC_RDn(src_rdn), .O_OBJ_AB(obj_ab),
      .O_OBJ_DB(obj_db), .O_OBJ_RQn(obj_rqn), .O_OBJ_WRn(obj_wrn), .O_BUSY(busy), .O_DONE(done)
   );

   function automatic logic [7:0] mem(input logic [15:0] a);
      logic [7:0] hi3;
      hi3 = 8'(a[15:8] * 3);
      return a[7:0] + hi3 + 8'h11;
   endfunction

   assign src_db = mem(src_ab);

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // CPU side: grants the bus two cycles after a request, takes it back when hold_bus is set
   initial begin
      int ack_cnt;
      ack_cnt = 0;
      forever begin
         @(negedge clk);
         #1;
         if (hold_bus || busrqn) begin
            ack_cnt = 0;
            busakn = 1;
         end else begin
            if (ack_cnt < 2) ack_cnt++;
            busakn = (ack_cnt < 2);
         end
      end
   end

   // every write is popped against the model queue; bus ownership and strobe shape checked each cycle
   initial begin
      wr_t w;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (!busrqn) rq_low_seen = 1;
            if (!src_rdn) last_sa = src_ab;
            if (!obj_wrn) begin
               check("wr_rq", obj_rqn, 0);
               check("wr_bus_owned", {busrqn, busakn}, 0);
               check("wr_width", prev_wrn, 1);
               if (chk_gap && log_cyc.size() > 0) check("wr_spacing", cyc - log_cyc[$], BPB);
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL wr_extra: got write at %h, required no write", obj_ab);
               end else begin
                  w = exp_q.pop_front();
                  check("wr_addr", obj_ab, w.ab);
                  check("wr_data", obj_db, w.db);
                  check("wr_src", last_sa, w.sa);
               end
               log_ab.push_back(obj_ab);
               log_db.push_back(obj_db);
               log_cyc.push_back(cyc);
            end
            if (done) begin
               check("done_width", prev_done, 0);
               done_cnt++;
               done_cyc = cyc;
            end
            prev_wrn = obj_wrn;
            prev_done = done;
         end else begin
            prev_wrn = 1;
            prev_done = 0;
         end
      end
   end

   task automatic model_xfer(input logic [15:0] b, input logic [9:0] l, input logic p);
      int eff;
      eff = (l > 512) ? 512 : int'(l);
      for (int i = 0; i < eff; i++) exp_q.push_back('{{~p, 9'(i)}, mem(b + 16'(i)), b + 16'(i)});
   endtask

   task automatic new_test();
      log_ab.delete();
      log_db.delete();
      log_cyc.delete();
      done_cnt = 0;
      rq_low_seen = 0;
   endtask

   task automatic pulse_start(input logic [15:0] b, input logic [9:0] l, input logic p, output int c, output logic bz);
      @(negedge clk);
      #2;
      base = b;
      len = l;
      psl = p;
      start = 1;
      c = cyc;
      @(negedge clk);
      #2;
      start = 0;
      bz = busy;
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int k;
      k = 0;
      while (done_cnt < target && k < budget) begin
         @(negedge clk);
         #3;
         k++;
      end
      check(name, done_cnt, target);
   endtask

   initial begin
      int c, k, n_w;
      logic bz;
      repeat (3) @(negedge clk);
      check("rst_strobes", {busrqn, src_rdn, obj_rqn, obj_wrn}, 4'hF);
      check("rst_addr_data", {src_ab, obj_ab, obj_db}, 0);
      check("rst_flags", {busy, done}, 0);
      rst_n = 1;

      // base transfer
      new_test();
      chk_gap = 1;
      model_xfer(16'h7000, 10'd4, 1'b0);
      pulse_start(16'h7000, 10'd4, 1'b0, c, bz);
      check("base_busy", bz, 1);
      wait_done(1, 100, "base_done");
      check("base_nwr", log_ab.size(), 4);
      check("base_first_ab", log_ab[0], 10'h200);
      check("base_first_db", log_db[0], 8'h61);
      check("base_last_ab", log_ab[3], 10'h203);
      check("base_last_db", log_db[3], 8'h64);
      check("base_first_lat", log_cyc[0] - c, 5);
      check("base_done_lat", done_cyc - c, 2 + 4 * BPB + 1);
      repeat (3) @(negedge clk);
      #3;
      check("base_release", {busrqn, busy}, 2'b10);
      check("base_one_done", done_cnt, 1);
      check("base_queue", exp_q.size(), 0);

      // source wrap into bank 0
      new_test();
      model_xfer(16'hFFFE, 10'd3, 1'b1);
      pulse_start(16'hFFFE, 10'd3, 1'b1, c, bz);
      wait_done(1, 100, "wrap_done");
      check("wrap_nwr", log_ab.size(), 3);
      check("wrap_first_ab", log_ab[0], 10'h000);
      check("wrap_last_ab", log_ab[2], 10'h002);
      check("wrap_last_db", log_db[2], 8'h11);
      check("wrap_queue", exp_q.size(), 0);

      // zero length
      new_test();
      pulse_start(16'h1000, 10'd0, 1'b0, c, bz);
      check("zero_busy", bz, 0);
      wait_done(1, 10, "zero_done");
      check("zero_lat", done_cyc - c, 1);
      repeat (5) @(negedge clk);
      #3;
      check("zero_no_busrq", rq_low_seen, 0);
      check("zero_one_done", done_cnt, 1);

      // length clamp
      new_test();
      model_xfer(16'h2000, 10'h3FF, 1'b0);
      pulse_start(16'h2000, 10'h3FF, 1'b0, c, bz);
      wait_done(1, 3000, "clamp_done");
      check("clamp_nwr", log_ab.size(), 512);
      check("clamp_last_ab", log_ab[511], 10'h3FF);
      check("clamp_queue", exp_q.size(), 0);

      // bus reclaim, restart ignored while busy and at release
      new_test();
      chk_gap = 0;
      model_xfer(16'h1234, 10'd6, 1'b0);
      pulse_start(16'h1234, 10'd6, 1'b0, c, bz);
      n_w = 0;
      k = 0;
      while (n_w < 2 && k < 100) begin
         @(negedge clk);
         if (!obj_wrn) n_w++;
         k++;
      end
      hold_bus = 1;
      repeat (3) @(negedge clk);
      #3;
      check("hold_busrq", busrqn, 0);
      check("hold_strobes", {src_rdn, obj_rqn, obj_wrn}, 3'b111);
      start = 1;
      base = 16'h9000;
      @(negedge clk);
      #2;
      start = 0;
      repeat (3) @(negedge clk);
      #3;
      check("hold_nwr", log_ab.size(), 2);
      hold_bus = 0;
      k = 0;
      while (!done && k < 100) begin
         @(negedge clk);
         k++;
      end
      #2;
      start = 1;
      @(negedge clk);
      #2;
      start = 0;
      check("resume_nwr", log_ab.size(), 6);
      check("resume_ab", log_ab[2], 10'h202);
      check("resume_db", log_db[2], 8'h7D);
      rq_low_seen = 0;
      repeat (20) @(negedge clk);
      #3;
      check("rel_start_ignored", rq_low_seen, 0);
      check("reclaim_one_done", done_cnt, 1);
      check("reclaim_queue", exp_q.size(), 0);

      // asynchronous reset during a write
      new_test();
      model_xfer(16'h4000, 10'd4, 1'b0);
      pulse_start(16'h4000, 10'd4, 1'b0, c, bz);
      k = 0;
      while (obj_wrn && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("rst_mid_reached", obj_wrn, 0);
      #2;
      rst_n = 0;
      #1;
      check("rst_mid_strobes", {busrqn, src_rdn, obj_wrn, obj_rqn}, 4'hF);
      check("rst_mid_busy", busy, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1;
      new_test();
      model_xfer(16'h0010, 10'd2, 1'b1);
      pulse_start(16'h0010, 10'd2, 1'b1, c, bz);
      wait_done(1, 100, "after_rst_done");
      check("after_rst_queue", exp_q.size(), 0);

`ifdef DMA_VBLANK_GATE_EN
      // start outside vertical blank waits for it
      new_test();
      vblk = 0;
      model_xfer(16'h5000, 10'd2, 1'b0);
      pulse_start(16'h5000, 10'd2, 1'b0, c, bz);
      check("gate_busy", bz, 1);
      repeat (10) @(negedge clk);
      #3;
      check("gate_no_busrq", rq_low_seen, 0);
      vblk = 1;
      wait_done(1, 100, "gate_done");
      check("gate_nwr", log_ab.size(), 2);
      check("gate_queue", exp_q.size(), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
